regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 integer register file (x0 hardwired to zero).
- Round-robin arbitration among NREQ writeback producers (e.g. ALU, load unit, CSR unit) through a valid/ready handshake.
- Drives the register file write port from a one-entry output register.
- Keeps a pending-write scoreboard so the issue stage can stall on RAW/WAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin writeback arbiter that owns the single write
//                port of the 32x32 integer register file, with a one-entry
//                output register and a pending-write scoreboard for issue
//                hazard detection.
//                Optional macro REGFILE_ARB_BYPASS_EN enables the
//                wr_data forwarding indications (rs1_fwd / rs2_fwd).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_rd,
   input  logic [ADDR_W-1:0]        rs1_addr,
   input  logic [ADDR_W-1:0]        rs2_addr,
   output logic                     rs1_hazard,
   output logic                     rs2_hazard,
   output logic                     rd_hazard,
   output logic                     rs1_fwd,
   output logic                     rs2_fwd,
   output logic [31:0]              busy_vec
);

   localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Registered state
   logic [c_PTR_W-1:0] rr_ptr_q,  rr_ptr_d;
   logic               wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [31:0]        busy_q,    busy_d;

   // Combinational arbitration results
   logic [ADDR_W-1:0]  w_addr_arr [NREQ];
   logic [DATA_W-1:0]  w_data_arr [NREQ];
   logic [c_PTR_W-1:0] w_scan_idx;
   logic [c_PTR_W-1:0] w_grant_idx;
   logic               w_grant_vld;
   logic               w_transfer;
   logic [ADDR_W-1:0]  w_gnt_addr;
   logic [DATA_W-1:0]  w_gnt_data;

   // Split the flat request buses into per-requester fields
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin scan starting at rr_ptr; first valid requester wins
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_scan_idx = c_PTR_W'((int'(rr_ptr_q) + k) % NREQ);
         if (!w_grant_vld && req_valid[w_scan_idx]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_scan_idx;
         end
      end
   end

   // Grants are suppressed while in reset so nothing is consumed
   assign w_transfer = w_grant_vld && !rst;
   assign w_gnt_addr = w_addr_arr[w_grant_idx];
   assign w_gnt_data = w_data_arr[w_grant_idx];

   // One-hot ready towards the granted requester
   always_comb begin
      req_ready = '0;
      if (w_transfer) begin
         req_ready[w_grant_idx] = 1'b1;
      end
   end

   // Next-state for pointer, output register and scoreboard
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;

      if (w_transfer) begin
         if (w_grant_idx == c_PTR_W'(NREQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = w_grant_idx + 1'b1;
         end
         // x0 writes are consumed but never reach the register file
         wr_en_d   = (w_gnt_addr != '0);
         wr_addr_d = w_gnt_addr;
         wr_data_d = w_gnt_data;
      end

      // Clear first so a same-edge set for a newer producer wins
      if (wr_en) begin
         busy_d[wr_addr_q] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   // An in-flight write is dropped if reset arrives while it is presented
   assign wr_en    = wr_en_q && !rst;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy_vec = busy_q;

`ifdef REGFILE_ARB_BYPASS_EN
   // Source operands can take wr_data directly during the write cycle
   assign rs1_fwd = wr_en && (wr_addr_q == rs1_addr) && (rs1_addr != '0);
   assign rs2_fwd = wr_en && (wr_addr_q == rs2_addr) && (rs2_addr != '0);
`else
   assign rs1_fwd = 1'b0;
   assign rs2_fwd = 1'b0;
`endif

   // Hazards are busy-based, masked when the operand is being forwarded
   assign rs1_hazard = busy_q[rs1_addr] && (rs1_addr != '0) && !rs1_fwd;
   assign rs2_hazard = busy_q[rs2_addr] && (rs2_addr != '0) && !rs2_fwd;
   assign rd_hazard  = busy_q[issue_rd] && (issue_rd != '0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter: directed
//                scenarios followed by randomized traffic compared against
//                a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int NREQ   = 3;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   issue_valid;
   logic [ADDR_W-1:0]      issue_rd;
   logic [ADDR_W-1:0]      rs1_addr;
   logic [ADDR_W-1:0]      rs2_addr;
   logic                   rs1_hazard;
   logic                   rs2_hazard;
   logic                   rd_hazard;
   logic                   rs1_fwd;
   logic                   rs2_fwd;
   logic [31:0]            busy_vec;

   regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_hazard  (rs1_hazard),
      .rs2_hazard  (rs2_hazard),
      .rd_hazard   (rd_hazard),
      .rs1_fwd     (rs1_fwd),
      .rs2_fwd     (rs2_fwd),
      .busy_vec    (busy_vec)
   );

   always #5 clk = ~clk;

   // Requester-side stimulus
   logic [NREQ-1:0]   rv;
   logic [ADDR_W-1:0] ra   [NREQ];
   logic [DATA_W-1:0] rdat [NREQ];

   // Reference model state
   int                m_ptr;
   logic              m_wr_en;
   logic [ADDR_W-1:0] m_wr_addr;
   logic [DATA_W-1:0] m_wr_data;
   logic [31:0]       m_busy;
   int                last_grant;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      for (int k = 0; k < NREQ; k++) begin
         if (rv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Apply the stimulus arrays to the DUT and let logic settle
   task automatic settle();
      req_valid = rv;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = ra[i];
         req_data[i*DATA_W +: DATA_W] = rdat[i];
      end
      #1;
   endtask

   // Check every output against the model, advance the model over the edge
   task automatic cycle(input string tag);
      int                g;
      logic [NREQ-1:0]   e_ready;
      logic              e_wen, e_f1, e_f2;
      g       = model_grant();
      e_ready = '0;
      if (!rst && g >= 0) e_ready[g] = 1'b1;
      e_wen = m_wr_en && !rst;
`ifdef REGFILE_ARB_BYPASS_EN
      e_f1 = e_wen && (m_wr_addr == rs1_addr) && (rs1_addr != 0);
      e_f2 = e_wen && (m_wr_addr == rs2_addr) && (rs2_addr != 0);
`else
      e_f1 = 1'b0;
      e_f2 = 1'b0;
`endif
      chk({tag, ":ready"},   64'(req_ready),  64'(e_ready));
      chk({tag, ":wr_en"},   64'(wr_en),      64'(e_wen));
      chk({tag, ":wr_addr"}, 64'(wr_addr),    64'(m_wr_addr));
      chk({tag, ":wr_data"}, 64'(wr_data),    64'(m_wr_data));
      chk({tag, ":busy"},    64'(busy_vec),   64'(m_busy));
      chk({tag, ":rs1_haz"}, 64'(rs1_hazard), 64'(m_busy[rs1_addr] && rs1_addr != 0 && !e_f1));
      chk({tag, ":rs2_haz"}, 64'(rs2_hazard), 64'(m_busy[rs2_addr] && rs2_addr != 0 && !e_f2));
      chk({tag, ":rd_haz"},  64'(rd_hazard),  64'(m_busy[issue_rd] && issue_rd != 0));
      chk({tag, ":rs1_fwd"}, 64'(rs1_fwd),    64'(e_f1));
      chk({tag, ":rs2_fwd"}, 64'(rs2_fwd),    64'(e_f2));

      if (rst) begin
         last_grant = -1;
         m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_busy = '0;
      end else begin
         last_grant = g;
         if (e_wen) m_busy[m_wr_addr] = 1'b0;
         if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
         if (g >= 0) begin
            m_wr_en   = (ra[g] != 0);
            m_wr_addr = ra[g];
            m_wr_data = rdat[g];
            m_ptr     = (g + 1) % NREQ;
         end else begin
            m_wr_en = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
      rv = 3'b111;
      ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
      rdat[0] = 32'hAAAA_0001; rdat[1] = 32'hBBBB_0002; rdat[2] = 32'hCCCC_0003;
      m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_busy = '0;
      last_grant = -1;
      settle();
      @(posedge clk);
      #1;

      // Reset held two cycles with every requester valid
      settle(); cycle("rst0");
      settle();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_busy",  64'(busy_vec), 64'd0);
      cycle("rst1");

      // Round-robin with all three valid
      rst = 1'b0;
      settle(); chk("rr_g0", 64'(req_ready), 64'b001); cycle("rr0");
      settle(); chk("rr_g1", 64'(req_ready), 64'b010);
      chk("rr_w1", {wr_en, 27'd0, wr_addr, wr_data}, {1'b1, 27'd0, 5'd1, 32'hAAAA_0001});
      cycle("rr1");
      settle(); chk("rr_g2", 64'(req_ready), 64'b100);
      chk("rr_w2", {wr_en, 27'd0, wr_addr, wr_data}, {1'b1, 27'd0, 5'd2, 32'hBBBB_0002});
      cycle("rr2");
      settle(); chk("rr_g3", 64'(req_ready), 64'b001);
      chk("rr_w3", {wr_en, 27'd0, wr_addr, wr_data}, {1'b1, 27'd0, 5'd3, 32'hCCCC_0003});
      cycle("rr3");
      rv = '0; settle(); cycle("rr4");

      // x0 write from requester 1
      rv = 3'b010; ra[1] = 5'd0; rdat[1] = 32'hFFFF_FFFF;
      settle(); chk("x0_ready", 64'(req_ready), 64'b010); cycle("x0a");
      rv = '0; settle(); chk("x0_noen", 64'(wr_en), 64'd0); cycle("x0b");
      rv = 3'b111; ra[1] = 5'd2;
      settle(); chk("x0_next", 64'(req_ready), 64'b100); cycle("x0c");
      rv = '0; settle(); cycle("x0d");

      // Scoreboard set / clear
      issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
      settle(); cycle("sb0");
      issue_valid = 1'b0; rv = 3'b001; ra[0] = 5'd5; rdat[0] = 32'h5555_0055;
      settle();
      chk("sb_busy5", 64'(busy_vec[5]), 64'd1);
      chk("sb_rs1h",  64'(rs1_hazard), 64'd1);
      cycle("sb1");
      rv = '0; settle();
      chk("sb_wen", 64'(wr_en), 64'd1);
      chk("sb_busy_hold", 64'(busy_vec[5]), 64'd1);
      cycle("sb2");
      settle(); chk("sb_clr", 64'(busy_vec[5]), 64'd0); cycle("sb3");

      // Same-edge set and clear of x5: set wins
      issue_valid = 1'b1; issue_rd = 5'd5; settle(); cycle("sw0");
      issue_valid = 1'b0; rv = 3'b001; rdat[0] = 32'h6666_0066; settle(); cycle("sw1");
      rv = '0; issue_valid = 1'b1; issue_rd = 5'd5; settle(); cycle("sw2");
      issue_valid = 1'b0; settle(); chk("sw_setwins", 64'(busy_vec[5]), 64'd1); cycle("sw3");
      rv = 3'b001; settle(); cycle("sw4");
      rv = '0; settle(); cycle("sw5");
      settle(); chk("sw_clr", 64'(busy_vec[5]), 64'd0); cycle("sw6");

      // Bypass indication on x7
      issue_valid = 1'b1; issue_rd = 5'd7; settle(); cycle("bp0");
      issue_valid = 1'b0; rv = 3'b001; ra[0] = 5'd7; rdat[0] = 32'h7777_0077; settle(); cycle("bp1");
      rv = '0; rs2_addr = 5'd7; settle();
      chk("bp_wen", {wr_en, 27'd0, wr_addr}, {1'b1, 27'd0, 5'd7});
`ifdef REGFILE_ARB_BYPASS_EN
      chk("bp_fwd", 64'(rs2_fwd), 64'd1);
      chk("bp_haz", 64'(rs2_hazard), 64'd0);
`else
      chk("bp_fwd", 64'(rs2_fwd), 64'd0);
      chk("bp_haz", 64'(rs2_hazard), 64'd1);
`endif
      cycle("bp2");

      // Reset right after an accept drops the write
      issue_valid = 1'b1; issue_rd = 5'd9; rv = 3'b001; ra[0] = 5'd9; rdat[0] = 32'h9999_0099;
      settle(); cycle("mr0");
      issue_valid = 1'b0; rv = '0; rst = 1'b1;
      settle(); chk("mr_noen", 64'(wr_en), 64'd0); cycle("mr1");
      rst = 1'b0;
      settle();
      chk("mr_busy", 64'(busy_vec), 64'd0);
      chk("mr_wen",  64'(wr_en), 64'd0);
      cycle("mr2");

      // Randomized traffic under the requester hold rule
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] || i == last_grant) begin
               rv[i]   = ($urandom_range(0, 2) != 0);
               ra[i]   = ADDR_W'($urandom_range(0, 31));
               rdat[i] = $urandom;
            end
         end
         issue_rd    = ADDR_W'($urandom_range(0, 31));
         issue_valid = ($urandom_range(0, 1) == 1) && !m_busy[issue_rd];
         rs1_addr    = ($urandom_range(0, 1) == 1) ? m_wr_addr : ADDR_W'($urandom_range(0, 31));
         rs2_addr    = ($urandom_range(0, 1) == 1) ? m_wr_addr : ADDR_W'($urandom_range(0, 31));
         rst         = ($urandom_range(0, 99) == 0);
         settle();
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
